// File: rtl/vga_fb_pkg.sv
// Shared constants, write-FSM states and framebuffer address mapping for the
// 160x120x3 pixel framebuffer.
package vga_fb_pkg;

  localparam int unsigned SCREEN_W = 160;
  localparam int unsigned SCREEN_H = 120;
  localparam int unsigned FB_DEPTH = 19200;
  localparam int unsigned ADDR_W   = 15;
  localparam int unsigned COLOUR_W = 3;

  localparam logic [ADDR_W-1:0] FB_LAST = ADDR_W'(FB_DEPTH - 1);

  typedef enum logic {
    ST_CLEAR,
    ST_IDLE
  } wr_state_e;

  // y*160 + x as y*128 + y*32 + x
  function automatic logic [ADDR_W-1:0] fb_addr(input logic [7:0] x, input logic [6:0] y);
    return {1'b0, y, 7'b0} + {3'b0, y, 5'b0} + {7'b0, x};
  endfunction

endpackage

// File: rtl/fb_ram.sv
// Simple dual-port framebuffer RAM: one write port, one registered read port
// returning the old word when both ports hit the same address.
module fb_ram
  import vga_fb_pkg::*;
#(
  parameter int unsigned DEPTH = FB_DEPTH
) (
  input  logic                clk_i,
  input  logic                we_i,
  input  logic [ADDR_W-1:0]   waddr_i,
  input  logic [COLOUR_W-1:0] wdata_i,
  input  logic                re_i,
  input  logic [ADDR_W-1:0]   raddr_i,
  output logic [COLOUR_W-1:0] rdata_o
);

  logic [COLOUR_W-1:0] mem [DEPTH];
  logic [COLOUR_W-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) mem[waddr_i] <= wdata_i;
    if (re_i) rdata_q <= mem[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/vga_frame_scanner.sv
// Pixel-plot responder: write FSM with clear engine and drop counter, plus a
// free-running raster scanner with a 2-stage aligned output pipeline.
module vga_frame_scanner
  import vga_fb_pkg::*;
#(
  parameter int unsigned X_SCREEN_PIXELS = 160,
  parameter int unsigned Y_SCREEN_PIXELS = 120,
  parameter int unsigned H_TOTAL         = 200,
  parameter int unsigned V_TOTAL         = 125,
  parameter int unsigned HSYNC_START     = 168,
  parameter int unsigned HSYNC_LEN       = 16,
  parameter int unsigned VSYNC_START     = 121,
  parameter int unsigned VSYNC_LEN       = 2
) (
  input  logic       iClock,
  input  logic       iResetn,
  input  logic [7:0] iX,
  input  logic [6:0] iY,
  input  logic [2:0] iColour,
  input  logic       iPlot,
  input  logic       iClear,
  output logic       oBusy,
  output logic [7:0] oDropCount,
  output logic [7:0] oScanX,
  output logic [6:0] oScanY,
  output logic [2:0] oPixColour,
  output logic       oPixValid,
  output logic       oHSync,
  output logic       oVSync,
  output logic       oFrameStart
);

  localparam logic [7:0] HC_LAST = 8'(H_TOTAL - 1);
  localparam logic [7:0] X_ACT   = 8'(X_SCREEN_PIXELS);
  localparam logic [7:0] HS_BEG  = 8'(HSYNC_START);
  localparam logic [7:0] HS_END  = 8'(HSYNC_START + HSYNC_LEN);
  localparam logic [6:0] VC_LAST = 7'(V_TOTAL - 1);
  localparam logic [6:0] Y_ACT   = 7'(Y_SCREEN_PIXELS);
  localparam logic [6:0] VS_BEG  = 7'(VSYNC_START);
  localparam logic [6:0] VS_END  = 7'(VSYNC_START + VSYNC_LEN);

  wr_state_e           state_q, state_d;
  logic [ADDR_W-1:0]   clr_addr_q, clr_addr_d;
  logic [7:0]          drop_q, drop_d;
  logic                we, drop;
  logic [ADDR_W-1:0]   waddr, raddr;
  logic [COLOUR_W-1:0] wdata, rdata;

  always_comb begin
    state_d    = state_q;
    clr_addr_d = clr_addr_q;
    we         = 1'b0;
    waddr      = fb_addr(iX, iY);
    wdata      = iColour;
    drop       = 1'b0;
    case (state_q)
      ST_CLEAR: begin
        we         = 1'b1;
        waddr      = clr_addr_q;
        wdata      = '0;
        clr_addr_d = clr_addr_q + ADDR_W'(1);
        drop       = iPlot;
        if (clr_addr_q == FB_LAST) state_d = ST_IDLE;
      end
      ST_IDLE: begin
        if (iClear) begin
          state_d    = ST_CLEAR;
          clr_addr_d = '0;
          drop       = iPlot;
        end else if (iPlot) begin
          if (iX < X_ACT && iY < Y_ACT) we = 1'b1;
          else drop = 1'b1;
        end
      end
      default: state_d = ST_CLEAR;
    endcase
    drop_d = (drop && drop_q != 8'hFF) ? drop_q + 8'd1 : drop_q;
  end

  always_ff @(posedge iClock or negedge iResetn) begin
    if (!iResetn) begin
      state_q    <= ST_CLEAR;
      clr_addr_q <= '0;
      drop_q     <= '0;
    end else begin
      state_q    <= state_d;
      clr_addr_q <= clr_addr_d;
      drop_q     <= drop_d;
    end
  end

  logic [7:0] hc_q, hc_d;
  logic [6:0] vc_q, vc_d;
  logic       active0, hs0, vs0, fs0;

  always_comb begin
    hc_d = (hc_q == HC_LAST) ? '0 : hc_q + 8'd1;
    vc_d = vc_q;
    if (hc_q == HC_LAST) vc_d = (vc_q == VC_LAST) ? '0 : vc_q + 7'd1;
    active0 = (hc_q < X_ACT) && (vc_q < Y_ACT);
    hs0     = !(hc_q >= HS_BEG && hc_q < HS_END);
    vs0     = !(vc_q >= VS_BEG && vc_q < VS_END);
    fs0     = (hc_q == '0) && (vc_q == '0);
    raddr   = fb_addr(hc_q, vc_q);
  end

  fb_ram #(.DEPTH(FB_DEPTH)) u_ram (
    .clk_i   (iClock),
    .we_i    (we),
    .waddr_i (waddr),
    .wdata_i (wdata),
    .re_i    (active0),
    .raddr_i (raddr),
    .rdata_o (rdata)
  );

  logic [7:0] x1_q, x2_q;
  logic [6:0] y1_q, y2_q;
  logic       v1_q, hs1_q, vs1_q, fs1_q, blank1_q;
  logic       v2_q, hs2_q, vs2_q, fs2_q;
  logic [2:0] pix_q, pix_d;

  // Blank reads issued mid-clear as well as during the presenting cycle, so
  // words not yet overwritten by the clear never reach the pins.
  always_comb begin
    pix_d = (v1_q && !blank1_q && state_d == ST_IDLE) ? rdata : '0;
  end

  always_ff @(posedge iClock or negedge iResetn) begin
    if (!iResetn) begin
      hc_q     <= '0;
      vc_q     <= '0;
      x1_q     <= '0;
      y1_q     <= '0;
      v1_q     <= 1'b0;
      hs1_q    <= 1'b1;
      vs1_q    <= 1'b1;
      fs1_q    <= 1'b0;
      blank1_q <= 1'b1;
      x2_q     <= '0;
      y2_q     <= '0;
      v2_q     <= 1'b0;
      hs2_q    <= 1'b1;
      vs2_q    <= 1'b1;
      fs2_q    <= 1'b0;
      pix_q    <= '0;
    end else begin
      hc_q     <= hc_d;
      vc_q     <= vc_d;
      x1_q     <= hc_q;
      y1_q     <= vc_q;
      v1_q     <= active0;
      hs1_q    <= hs0;
      vs1_q    <= vs0;
      fs1_q    <= fs0;
      blank1_q <= (state_q == ST_CLEAR);
      x2_q     <= x1_q;
      y2_q     <= y1_q;
      v2_q     <= v1_q;
      hs2_q    <= hs1_q;
      vs2_q    <= vs1_q;
      fs2_q    <= fs1_q;
      pix_q    <= pix_d;
    end
  end

  assign oBusy       = (state_q == ST_CLEAR);
  assign oDropCount  = drop_q;
  assign oScanX      = x2_q;
  assign oScanY      = y2_q;
  assign oPixColour  = pix_q;
  assign oPixValid   = v2_q;
  assign oHSync      = hs2_q;
  assign oVSync      = vs2_q;
  assign oFrameStart = fs2_q;

endmodule

// File: doc/vga_frame_scanner.md
# vga_frame_scanner

Responder end of the pixel-plot interface: accepts single-pixel writes (x, y, colour, plot strobe) from drawing engines into a 160x120x3-bit framebuffer and continuously scans the framebuffer out in raster order with sync timing. It sits between the box/line plotters and the VGA output pins. It also owns framebuffer clearing: automatically after reset and on request.

## Interface
Parameters:
- X_SCREEN_PIXELS, 160, active pixels per line
- Y_SCREEN_PIXELS, 120, active lines per frame
- H_TOTAL, 200, scan-counter clocks per line (active + blanking)
- V_TOTAL, 125, lines per frame
- HSYNC_START, 168, hc at which oHSync asserts; HSYNC_LEN, 16, its length in clocks
- VSYNC_START, 121, vc at which oVSync asserts; VSYNC_LEN, 2, its length in lines

Ports:
- iClock  in  1  sole clock, rising edge
- iResetn  in  1  reset, asynchronous, active-low
- iX  in  8  plot x coordinate
- iY  in  7  plot y coordinate
- iColour  in  3  plot colour
- iPlot  in  1  write strobe, one pixel per high cycle
- iClear  in  1  request black-fill of framebuffer
- oBusy  out  1  clear in progress; plots dropped
- oDropCount  out  8  saturating count of dropped plots
- oScanX  out  8  x of the pixel currently presented
- oScanY  out  7  y of the pixel currently presented
- oPixColour  out  3  colour of the presented pixel; 0 outside active area
- oPixValid  out  1  presented pixel is inside the active area
- oHSync, oVSync  out  1 each  sync pulses, active-low
- oFrameStart  out  1  one-cycle pulse coincident with pixel (0,0) presentation

## Operation
- Address = y*160 + x = (y<<7)+(y<<5)+x, 15 bits; no multiplier.
- Write FSM states: CLEAR, IDLE.
  - CLEAR: writes colour 0 at clr_addr, increments clr_addr each cycle; after address 19199 written, goes to IDLE. oBusy=1.
  - IDLE: iPlot=1 with iX<160 and iY<120 writes iColour. iPlot with out-of-range coordinates is dropped. iClear=1 moves to CLEAR with clr_addr=0.
  - iClear and iPlot in the same IDLE cycle: clear wins; that plot is dropped.
  - iClear while in CLEAR: ignored (no restart).
  - iPlot in CLEAR: dropped.
- Each dropped plot increments oDropCount; saturates at 255; cleared only by reset.
- Scan counters hc (0..H_TOTAL-1) and vc (0..V_TOTAL-1) run freely from reset. hc wraps to 0 and increments vc; vc wraps to 0 after V_TOTAL-1.
- Active when hc<160 and vc<120. The read address is issued only when active.
- oHSync is low for HSYNC_START<=hc<HSYNC_START+HSYNC_LEN. oVSync is low for VSYNC_START<=vc<VSYNC_START+VSYNC_LEN. Both are evaluated on the stage-0 counters and delayed with the data.
- While oBusy=1, oPixColour is forced to 0; oPixValid is unaffected.

## Timing
- Reset (asynchronous, iResetn=0):
  - state=CLEAR, clr_addr=0, hc=vc=0
  - oBusy=1, oDropCount=0, oScanX=0, oScanY=0, oPixColour=0, oPixValid=0
  - oHSync=1, oVSync=1, oFrameStart=0
- Reset deasserted mid-clear: the clear restarts from address 0.
- Clear duration is exactly 19200 cycles. oBusy falls in the cycle after address 19199 is written. A plot is accepted in the first cycle oBusy=0.
- Write latency: a plot accepted in cycle T is visible to a scan read issued in T+1 or later.
- A same-address read and write in one cycle returns the old data.
- Scan pipeline: counters in cycle T, RAM read in T+1, registered outputs in T+2. oScanX, oScanY, oPixValid, syncs and oFrameStart are delayed by 2 so all outputs stay aligned.
- oPixValid is high 160 consecutive cycles per active line and low for H_TOTAL-160 cycles. Frame period is H_TOTAL*V_TOTAL = 25000 cycles.

## Structure
- Package vga_fb_pkg holds:
  - screen constants (160, 120, FB_DEPTH=19200)
  - ADDR_W=15, COLOUR_W=3
  - write-FSM state enum (CLEAR, IDLE)
  - the address function
- Sub-module fb_ram: simple dual-port 19200x3 RAM, one write port, one synchronous read port, read-old on collision. Infers block RAM.
- Top-level holds the write FSM, drop counter, scan counters and the 2-stage alignment pipeline.

## Test plan
- Reset, then wait: oBusy=1 for exactly 19200 cycles. Afterwards every oPixValid pixel over a full frame has oPixColour=0.
- After clear, plot (5,7) colour 3'b101: in the next frame, oPixColour=5 only when oScanX=5, oScanY=7 with oPixValid=1; 0 elsewhere.
- Plot (160,0), (0,120) and (255,127): oDropCount=3, frame unchanged. Then 300 out-of-range plots: oDropCount=255.
- iClear and iPlot (10,10) colour 7 in the same cycle: oBusy=1 next cycle, oDropCount+1, pixel (10,10) reads 0 after the clear.
- Check sync timing: oFrameStart period is 25000 cycles; oHSync low for 16 cycles per line; oVSync low for 400 cycles per frame. oFrameStart coincides with oScanX=0, oScanY=0, oPixValid=1.
- Assert iResetn=0 mid-clear at clr_addr≈9000: outputs take their reset values immediately. After release, oBusy stays high a full 19200 cycles.
